serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_digit_adder.sv | 27 ++
 rtl/serial_adder.sv | 122 ++++++++++++
 tb/tb_serial_adder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_slices(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter needs at least one bit even when a single slice covers the word.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder for one slice; also exposes the carry into the slice MSB.
module digit_adder
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1]  = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
    end

    assign cout    = carry[DIGIT];
    assign msb_cin = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor with start/busy/done handshake, LS slice first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = num_slices(WIDTH, DIGIT);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] psum_reg;
    logic [WIDTH-1:0] psum_next;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;

    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             msb_cin;
`else
    logic             msb_cin_unused;
`endif

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a       (a_reg[DIGIT-1:0]),
        .b       (b_reg[DIGIT-1:0]),
        .cin     (carry_reg),
        .sum     (slice_sum),
        .cout    (slice_cout),
`ifdef SERIAL_ADDER_OVF_EN
        .msb_cin (msb_cin)
`else
        .msb_cin (msb_cin_unused)
`endif
    );

    // New slice enters at the MSB end so the LS slice lands at bit 0 after N shifts.
    if (WIDTH > DIGIT) begin : g_shift
        assign psum_next = {slice_sum, psum_reg[WIDTH-1:DIGIT]};
    end else begin : g_single
        assign psum_next = slice_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            psum_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                RUN: begin
                    a_reg     <= a_reg >> DIGIT;
                    b_reg     <= b_reg >> DIGIT;
                    carry_reg <= slice_cout;
                    psum_reg  <= psum_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        sum       <= psum_next;
                        cout      <= slice_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf       <= msb_cin ^ slice_cout;
`endif
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        // Subtraction is a + ~b + 1.
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8/DIGIT=2 and WIDTH=8/DIGIT=8 instances.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start, sub, cin;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    int checks = 0;
    int passes = 0;

    serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf8 = 1'b0;
`endif

    // Reference: plain integer arithmetic; {cout, sum}.
    function automatic logic [8:0] ref_result(input logic [7:0] x, input logic [7:0] y,
                                              input logic s, input logic c);
        int r;
        if (s) begin
            r = int'(x) - int'(y);
            return {(x >= y), 8'(r)};
        end
        r = int'(x) + int'(y) + int'(c);
        return 9'(r);
    endfunction

    function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y,
                                     input logic s, input logic c);
        int sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = s ? (sx - sy) : (sx + sy + int'(c));
        return (r > 127) || (r < -128);
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [7:0] x, input logic [7:0] y,
                         input logic s, input logic c);
        if (sel) begin
            start8 = st; a8 = x; b8 = y; sub8 = s; cin8 = c;
        end else begin
            start = st; a = x; b = y; sub = s; cin = c;
        end
    endtask

    // Runs one operation; inputs are scrambled while RUN to show they are not re-sampled.
    task automatic do_op(input bit sel, input logic [7:0] x, input logic [7:0] y,
                         input logic s, input logic c, input bit mid,
                         output logic [7:0] gs, output logic gc, output logic go,
                         output int lat, output bit busy_ok, output bit pulse_ok);
        @(negedge clk);
        drive(sel, 1'b1, x, y, s, c);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, x, y, s, c);
        lat = 0;
        busy_ok = ((sel ? busy8 : busy) === 1'b1);
        while (((sel ? done8 : done) !== 1'b1) && lat < 20) begin
            drive(sel, mid && lat == 1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            lat++;
            if ((sel ? done8 : done) !== 1'b1 && (sel ? busy8 : busy) !== 1'b1) busy_ok = 0;
        end
        if ((sel ? busy8 : busy) !== 1'b0) busy_ok = 0;
        drive(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        gs = sel ? sum8 : sum;
        gc = sel ? cout8 : cout;
        go = sel ? ovf8 : ovf;
        @(posedge clk);
        #1;
        pulse_ok = ((sel ? done8 : done) === 1'b0) && ((sel ? sum8 : sum) === gs);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
        checks++; if (sum !== 8'h00) $display("FAIL reset_sum: got %h want 00", sum); else passes++;
        checks++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout); else passes++;
        checks++; if (busy8 !== 1'b0) $display("FAIL reset_busy8: got %b want 0", busy8); else passes++;
        checks++; if (done8 !== 1'b0) $display("FAIL reset_done8: got %b want 0", done8); else passes++;
        checks++; if (sum8 !== 8'h00) $display("FAIL reset_sum8: got %h want 00", sum8); else passes++;
        checks++; if (cout8 !== 1'b0) $display("FAIL reset_cout8: got %b want 0", cout8); else passes++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] ta [5] = '{8'h7F, 8'hFF, 8'hFF, 8'h05, 8'h07};
        logic [7:0] tb [5] = '{8'h01, 8'h01, 8'h00, 8'h07, 8'h05};
        logic       ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] es [5] = '{8'h80, 8'h00, 8'h00, 8'hFE, 8'h02};
        logic       ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       eo [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] gs;
        logic       gc, go;
        int         lat;
        bit         bok, pok;
        for (int i = 0; i < 5; i++) begin
            do_op(0, ta[i], tb[i], ts[i], tc[i], 0, gs, gc, go, lat, bok, pok);
            $display("directed %0d: %h %s %h cin=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                     i, ta[i], ts[i] ? "-" : "+", tb[i], tc[i], gs, gc, go, lat);
            checks++; if (gs !== es[i]) $display("FAIL dir_sum[%0d]: got %h want %h", i, gs, es[i]); else passes++;
            checks++; if (gc !== ec[i]) $display("FAIL dir_cout[%0d]: got %b want %b", i, gc, ec[i]); else passes++;
            checks++; if (lat != 4) $display("FAIL dir_latency[%0d]: got %0d want 4", i, lat); else passes++;
            checks++; if (!bok) $display("FAIL dir_busy[%0d]: got bad want busy through RUN", i); else passes++;
            checks++; if (!pok) $display("FAIL dir_pulse[%0d]: got done>1 cycle or sum moved want 1-cycle", i); else passes++;
`ifdef SERIAL_ADDER_OVF_EN
            checks++; if (go !== eo[i]) $display("FAIL dir_ovf[%0d]: got %b want %b", i, go, eo[i]); else passes++;
`else
            if (eo[i] === 1'bx) $display("directed %0d: ovf table entry undefined", i);
`endif
        end
    endtask

    task automatic test_random(input bit sel, input int n, input int exp_lat);
        logic [7:0] x, y, gs;
        logic       s, c, gc, go;
        logic [8:0] e;
        int         lat;
        bit         bok, pok;
        for (int i = 0; i < n; i++) begin
            x = 8'($urandom); y = 8'($urandom); s = 1'($urandom); c = 1'($urandom);
            e = ref_result(x, y, s, c);
            do_op(sel, x, y, s, c, 0, gs, gc, go, lat, bok, pok);
            $display("random d%0d %0d: %h %s %h cin=%b -> sum=%h cout=%b lat=%0d",
                     sel ? 8 : 2, i, x, s ? "-" : "+", y, c, gs, gc, lat);
            checks++; if (gs !== e[7:0]) $display("FAIL rnd_sum: got %h want %h", gs, e[7:0]); else passes++;
            checks++; if (gc !== e[8]) $display("FAIL rnd_cout: got %b want %b", gc, e[8]); else passes++;
            checks++; if (lat != exp_lat) $display("FAIL rnd_latency: got %0d want %0d", lat, exp_lat); else passes++;
`ifdef SERIAL_ADDER_OVF_EN
            checks++; if (go !== ref_ovf(x, y, s, c)) $display("FAIL rnd_ovf: got %b want %b", go, ref_ovf(x, y, s, c)); else passes++;
`endif
        end
    endtask

    task automatic test_mid_start();
        logic [7:0] gs;
        logic       gc, go;
        int         lat;
        bit         bok, pok;
        do_op(0, 8'h3C, 8'h21, 1'b0, 1'b0, 1, gs, gc, go, lat, bok, pok);
        $display("mid_start: 3c + 21 -> sum=%h cout=%b lat=%0d", gs, gc, lat);
        checks++; if (gs !== 8'h5D) $display("FAIL mid_sum: got %h want 5d", gs); else passes++;
        checks++; if (gc !== 1'b0) $display("FAIL mid_cout: got %b want 0", gc); else passes++;
        checks++; if (lat != 4) $display("FAIL mid_latency: got %0d want 4", lat); else passes++;
    endtask

    task automatic test_back_to_back();
        int last, pulses;
        @(negedge clk);
        drive(0, 1'b1, 8'h9A, 8'h77, 1'b0, 1'b0);
        last = -1;
        pulses = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                $display("back_to_back: done at cycle %0d sum=%h cout=%b", cyc, sum, cout);
                checks++;
                if (last >= 0 && cyc - last != 5) $display("FAIL b2b_interval: got %0d want 5", cyc - last);
                else if (last < 0 && cyc != 4) $display("FAIL b2b_first: got %0d want 4", cyc);
                else passes++;
                checks++; if (sum !== 8'h11 || cout !== 1'b1) $display("FAIL b2b_result: got %b_%h want 1_11", cout, sum); else passes++;
                last = cyc;
                pulses++;
            end
        end
        checks++; if (pulses != 6) $display("FAIL b2b_count: got %0d want 6", pulses); else passes++;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] gs;
        logic       gc, go;
        int         lat;
        bit         bok, pok, saw_done;
        @(negedge clk);
        drive(0, 1'b1, 8'h55, 8'h66, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h55, 8'h66, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", busy); else passes++;
        #2 rst = 1'b1;
        #1;
        $display("reset_mid_run: busy=%b done=%b sum=%h cout=%b", busy, done, sum, cout);
        checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b want 0", done); else passes++;
        checks++; if (sum !== 8'h00) $display("FAIL rst_mid_sum: got %h want 00", sum); else passes++;
        checks++; if (cout !== 1'b0) $display("FAIL rst_mid_cout: got %b want 0", cout); else passes++;
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1;
        end
        checks++; if (saw_done) $display("FAIL rst_mid_no_done: got activity want idle"); else passes++;
        do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 0, gs, gc, go, lat, bok, pok);
        $display("after_reset: 12 + 34 -> sum=%h cout=%b lat=%0d", gs, gc, lat);
        checks++; if (gs !== 8'h46) $display("FAIL rst_after_sum: got %h want 46", gs); else passes++;
        checks++; if (gc !== 1'b0) $display("FAIL rst_after_cout: got %b want 0", gc); else passes++;
        checks++; if (lat != 4) $display("FAIL rst_after_latency: got %0d want 4", lat); else passes++;
    endtask

    task automatic test_full_digit();
        logic [7:0] gs;
        logic       gc, go;
        int         lat;
        bit         bok, pok;
        do_op(1, 8'hA5, 8'h5A, 1'b0, 1'b1, 0, gs, gc, go, lat, bok, pok);
        $display("full_digit: a5 + 5a cin=1 -> sum=%h cout=%b lat=%0d", gs, gc, lat);
        checks++; if (gs !== 8'h00) $display("FAIL fd_sum: got %h want 00", gs); else passes++;
        checks++; if (gc !== 1'b1) $display("FAIL fd_cout: got %b want 1", gc); else passes++;
        checks++; if (lat != 1) $display("FAIL fd_latency: got %0d want 1", lat); else passes++;
        checks++; if (!bok) $display("FAIL fd_busy: got bad want busy for one cycle"); else passes++;
        checks++; if (!pok) $display("FAIL fd_pulse: got done>1 cycle or sum moved want 1-cycle"); else passes++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(0, 24, 4);
        test_mid_start();
        test_back_to_back();
        test_reset_mid_run();
        test_full_digit();
        test_random(1, 8, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation timeout");
    end

endmodule
